// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Bimodal conditional-branch predictor for an in-order RISC-V front end.
// A 64-entry table of 2-bit saturating counters (indexed by pc[7:2]) gives a
// zero-latency taken/not-taken prediction for every fetched B-type instruction.
// Each branch that enters the pipeline is remembered in a 4-entry in-order
// queue. When execute resolves the oldest branch, the outcome is checked
// against the stored prediction and the counter is trained. A wrong prediction
// raises a redirect with the corrected fetch address and flushes the queue.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   if_valid        fetch-stage instruction valid
//   if_pc           address of the fetched instruction
//   if_instr        fetched instruction word
//   stall           front-end stall (same signal the PC register sees)
//   ex_valid        a conditional branch resolves in execute this cycle
//   ex_taken        actual outcome of that branch
//   pr_taken        predicted taken for the fetched instruction
//   pr_offs         B-type immediate of the fetched branch (0 if not a branch)
//   pr_miss         misprediction redirect request
//   br_addr         corrected fetch address, meaningful while pr_miss=1
//   bp_full         prediction queue full, front end must stall
// -----------------------------------------------------------------------------
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_taken,
  output logic        pr_taken,
  output logic [12:0] pr_offs,
  output logic        pr_miss,
  output logic [63:0] br_addr,
  output logic        bp_full
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] CTR_INIT   = 2'b01;   // weakly not-taken

  // Counter table
  logic [1:0]  ctr_q [64];
  logic [1:0]  ctr_d [64];

  // Queue storage and control
  logic [63:0] pc_q   [4];
  logic        pred_q [4];
  logic [12:0] offs_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q,  count_d;

  logic        is_br;
  logic        push;
  logic        pop;
  logic [5:0]  head_idx;
  logic [1:0]  head_ctr;
  logic [63:0] head_pc;
  logic [63:0] head_sext;

  // Only opcode and immediate fields of the instruction matter here.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^if_instr[24:12];

  // ---------------------------------------------------------------------------
  // Fetch side: decode and predict
  // ---------------------------------------------------------------------------
  assign is_br    = (if_instr[6:0] == OPC_BRANCH);
  assign bp_full  = (count_q == 3'd4);
  assign pr_taken = if_valid & is_br & ctr_q[if_pc[7:2]][1] & ~bp_full;
  assign pr_offs  = is_br ? {if_instr[31], if_instr[7], if_instr[30:25],
                             if_instr[11:8], 1'b0}
                          : 13'd0;

  // ---------------------------------------------------------------------------
  // Resolve side: compare against the oldest queued prediction
  // ---------------------------------------------------------------------------
  assign head_pc   = pc_q[rd_ptr_q];
  assign head_idx  = head_pc[7:2];
  assign head_ctr  = ctr_q[head_idx];
  assign head_sext = {{51{offs_q[rd_ptr_q][12]}}, offs_q[rd_ptr_q]};

  assign pop     = ex_valid & (count_q != 3'd0);
  assign pr_miss = pop & (ex_taken != pred_q[rd_ptr_q]);
  // Queue contents are unreset, so the address is forced to 0 while empty.
  assign br_addr = (count_q == 3'd0) ? 64'd0
                 : (ex_taken ? head_pc + head_sext : head_pc + 64'd4);

  // A pop frees a slot on the same edge, so a full queue still accepts a
  // push in a cycle that retires its head without a redirect. The stored
  // prediction is exactly what the front end saw on pr_taken.
  assign push = if_valid & is_br & ~stall & (~bp_full | pop) & ~pr_miss;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    ctr_d    = ctr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // Train the head's counter on every retire, redirect or not.
    if (pop) begin
      if (ex_taken && head_ctr != 2'b11) begin
        ctr_d[head_idx] = head_ctr + 2'd1;
      end else if (!ex_taken && head_ctr != 2'b00) begin
        ctr_d[head_idx] = head_ctr - 2'd1;
      end
    end

    if (pr_miss) begin
      // Everything younger than the head was fetched down the wrong path.
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the counter table is reset because its initial value (weakly
  // not-taken) is architecturally visible; the queue payload below is not,
  // since count gates every use of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ctr_q[i] <= CTR_INIT;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      ctr_q    <= ctr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]   <= if_pc;
      pred_q[wr_ptr_q] <= pr_taken;
      offs_q[wr_ptr_q] <= pr_offs;
    end
  end

endmodule
